hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port id_rs1_i / id_rs2_i  input  5 each  source register indices of the instruction in ID.
REQ-005 SHALL have port id_rs1_used_i / id_rs2_used_i  input  1 each  matching source index is read.
REQ-006 SHALL have port ex_rd_i  input  5  destination register of the instruction in EX.
REQ-007 SHALL have port ex_mem_read_i  input  1  the instruction in EX is a load.
REQ-008 SHALL have port ex_redirect_i  input  1  taken branch or jump resolved in EX.
REQ-009 SHALL have port ex_md_start_i  input  1  multi-cycle mul/div launched in EX this cycle.
REQ-010 SHALL have port md_done_i  input  1  mul/div result valid, one-cycle pulse.
REQ-011 SHALL have port mem_busy_i  input  1  data memory not ready; the whole pipeline must freeze.
REQ-012 SHALL have port pc_stall_o  output  1  PC holds its value.
REQ-013 SHALL have ports if_id_mode_o, id_ex_mode_o, ex_mem_mode_o, mem_wb_mode_o  output  2 each  pipeline-register control, bit0 = flush, bit1 = stall.
REQ-014 SHALL have port stall_cnt_o  output  CNT_W  cycles with pc_stall_o high.
REQ-015 SHALL have port flush_cnt_o  output  CNT_W  cycles with ex_redirect_i acted upon.

Function
REQ-016 SHALL implement a state register with states RUN, MD_WAIT; all mode/stall outputs are combinational from state plus current inputs.
REQ-017 SHALL never drive any mode output to 2'b11; modes used: 00 pass, 01 flush, 10 stall.
REQ-018 SHALL detect load-use when ex_mem_read_i=1, ex_rd_i!=0, and ex_rd_i equals (id_rs1_i with id_rs1_used_i) or (id_rs2_i with id_rs2_used_i).
REQ-019 SHALL apply priority, highest first: mem_busy_i, MD_WAIT state, ex_redirect_i, load-use, none.
REQ-020 SHALL, under mem_busy_i, drive pc_stall_o=1 and all four modes = 10.
REQ-021 SHALL, in MD_WAIT without mem_busy_i, drive pc_stall_o=1, if_id=10, id_ex=10, ex_mem=01, mem_wb=00.
REQ-022 SHALL, on ex_redirect_i in RUN without mem_busy_i, drive pc_stall_o=0, if_id=01, id_ex=01, ex_mem=00, mem_wb=00; load-use in the same cycle is ignored.
REQ-023 SHALL, on load-use alone, drive pc_stall_o=1, if_id=10, id_ex=01, others 00 (exactly one bubble per hazard).
REQ-024 SHALL otherwise drive pc_stall_o=0 and all modes 00.
REQ-025 SHALL go RUN->MD_WAIT at a clock edge where state=RUN, ex_md_start_i=1, md_done_i=0, mem_busy_i=0; with md_done_i=1 in the same cycle, it stays RUN.
REQ-026 SHALL keep a done_pend flag: set when md_done_i=1 in MD_WAIT while mem_busy_i=1; cleared on leaving MD_WAIT.
REQ-027 SHALL go MD_WAIT->RUN at an edge where (md_done_i or done_pend)=1 and mem_busy_i=0; no MD_WAIT->RUN while mem_busy_i=1.
REQ-028 SHALL ignore ex_md_start_i while in MD_WAIT or under mem_busy_i.
REQ-029 SHALL increment stall_cnt_o each edge where pc_stall_o=1, saturating at all-ones with no wrap.
REQ-030 SHALL increment flush_cnt_o each edge where REQ-022 applies, saturating at all-ones with no wrap.

Reset
REQ-031 SHALL, on rst_ni=0, immediately force state=RUN, done_pend=0, stall_cnt_o=0, flush_cnt_o=0, independent of clk_i.
REQ-032 SHALL, with rst_ni=0, output pc_stall_o=0 and all modes 00; an in-progress MD_WAIT is abandoned.
REQ-033 SHALL resume normal operation at the first rising edge after rst_ni deasserts.

Verification
REQ-034 SHALL cover: ex_mem_read_i=1, ex_rd_i=5, id_rs2_i=5, id_rs2_used_i=1 -> one cycle of pc_stall_o=1, if_id=10, id_ex=01; stall_cnt_o=1. With ex_rd_i=0 -> no stall.
REQ-035 SHALL cover: ex_redirect_i and load-use in the same cycle -> if_id=01, id_ex=01, pc_stall_o=0; flush_cnt_o=1, stall_cnt_o=0.
REQ-036 SHALL cover: ex_md_start_i pulse, then md_done_i 4 cycles later -> 4 cycles of MD_WAIT outputs (ex_mem=01), back to RUN; stall_cnt_o=4.
REQ-037 SHALL cover: md_done_i during mem_busy_i in MD_WAIT -> all modes 10 while busy; exit to RUN at the first edge with mem_busy_i=0.
REQ-038 SHALL cover: CNT_W=4 with 20 stall cycles -> stall_cnt_o holds at 15.
REQ-039 SHALL cover: rst_ni low mid-MD_WAIT between clock edges -> outputs 00 and counters 0 at once; RUN after release.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, redirect, multi-cycle mul/div and memory-busy
// handling for a 5-stage pipeline, plus saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_redirect_i,
  input  logic             ex_md_start_i,
  input  logic             md_done_i,
  input  logic             mem_busy_i,
  output logic             pc_stall_o,
  output logic [1:0]       if_id_mode_o,
  output logic [1:0]       id_ex_mode_o,
  output logic [1:0]       ex_mem_mode_o,
  output logic [1:0]       mem_wb_mode_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic {RUN, MD_WAIT} state_e;

  localparam logic [1:0] MODE_PASS  = 2'b00;
  localparam logic [1:0] MODE_FLUSH = 2'b01;
  localparam logic [1:0] MODE_STALL = 2'b10;

  state_e           state_q, state_d;
  logic             done_pend_q, done_pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic flush_act;

  always_comb begin
    load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
               ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
                (id_rs2_used_i && (id_rs2_i == ex_rd_i)));
  end

  // NOTE: every output of this block gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    pc_stall_o    = 1'b0;
    if_id_mode_o  = MODE_PASS;
    id_ex_mode_o  = MODE_PASS;
    ex_mem_mode_o = MODE_PASS;
    mem_wb_mode_o = MODE_PASS;
    flush_act     = 1'b0;
    // Held in reset the pipeline must see plain pass-through regardless of inputs.
    if (!rst_ni) begin
      pc_stall_o = 1'b0;
    end else if (mem_busy_i) begin
      pc_stall_o    = 1'b1;
      if_id_mode_o  = MODE_STALL;
      id_ex_mode_o  = MODE_STALL;
      ex_mem_mode_o = MODE_STALL;
      mem_wb_mode_o = MODE_STALL;
    end else if (state_q == MD_WAIT) begin
      // The mul/div occupies EX: hold the front, drain a bubble into MEM.
      pc_stall_o    = 1'b1;
      if_id_mode_o  = MODE_STALL;
      id_ex_mode_o  = MODE_STALL;
      ex_mem_mode_o = MODE_FLUSH;
    end else if (ex_redirect_i) begin
      if_id_mode_o = MODE_FLUSH;
      id_ex_mode_o = MODE_FLUSH;
      flush_act    = 1'b1;
    end else if (load_use) begin
      pc_stall_o   = 1'b1;
      if_id_mode_o = MODE_STALL;
      id_ex_mode_o = MODE_FLUSH;
    end
  end

  always_comb begin
    state_d     = state_q;
    done_pend_d = done_pend_q;
    unique case (state_q)
      RUN: begin
        if (ex_md_start_i && !md_done_i && !mem_busy_i) state_d = MD_WAIT;
      end
      MD_WAIT: begin
        if (mem_busy_i) begin
          // A completion seen while frozen is remembered until the freeze lifts.
          if (md_done_i) done_pend_d = 1'b1;
        end else if (md_done_i || done_pend_q) begin
          state_d     = RUN;
          done_pend_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_act && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      done_pend_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      done_pend_q <= done_pend_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed corner cases plus randomized traffic
// compared against a behavioural model; a narrow-counter instance checks saturation.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       used1, used2, mem_read, redirect, md_start, md_done, mem_busy;

  logic        pc_stall, pc_stall4;
  logic [1:0]  if_id, id_ex, ex_mem, mem_wb;
  logic [1:0]  if_id4, id_ex4, ex_mem4, mem_wb4;
  logic [15:0] stall_cnt, flush_cnt;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: is a mul/div outstanding, was its completion seen while
  // frozen, and how many stall / flush cycles occurred since reset (unbounded).
  bit m_md_outstanding;
  bit m_done_seen;
  int m_stalls;
  int m_flushes;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs1_used_i(used1), .id_rs2_used_i(used2),
    .ex_rd_i(rd), .ex_mem_read_i(mem_read), .ex_redirect_i(redirect),
    .ex_md_start_i(md_start), .md_done_i(md_done), .mem_busy_i(mem_busy),
    .pc_stall_o(pc_stall), .if_id_mode_o(if_id), .id_ex_mode_o(id_ex),
    .ex_mem_mode_o(ex_mem), .mem_wb_mode_o(mem_wb),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs1_used_i(used1), .id_rs2_used_i(used2),
    .ex_rd_i(rd), .ex_mem_read_i(mem_read), .ex_redirect_i(redirect),
    .ex_md_start_i(md_start), .md_done_i(md_done), .mem_busy_i(mem_busy),
    .pc_stall_o(pc_stall4), .if_id_mode_o(if_id4), .id_ex_mode_o(id_ex4),
    .ex_mem_mode_o(ex_mem4), .mem_wb_mode_o(mem_wb4),
    .stall_cnt_o(stall_cnt4), .flush_cnt_o(flush_cnt4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Expected {pc_stall, if_id, id_ex, ex_mem, mem_wb} from the priority rules.
  function automatic logic [8:0] model_out();
    bit hit1 = used1 && (rs1 == rd);
    bit hit2 = used2 && (rs2 == rd);
    bit lu   = mem_read && (rd != 0) && (hit1 || hit2);
    if (!rst_n)           return 9'b0_00_00_00_00;
    if (mem_busy)         return 9'b1_10_10_10_10;
    if (m_md_outstanding) return 9'b1_10_10_01_00;
    if (redirect)         return 9'b0_01_01_00_00;
    if (lu)               return 9'b1_10_01_00_00;
    return 9'b0_00_00_00_00;
  endfunction

  function automatic void model_reset();
    m_md_outstanding = 0;
    m_done_seen      = 0;
    m_stalls         = 0;
    m_flushes        = 0;
  endfunction

  function automatic void model_edge();
    logic [8:0] o = model_out();
    if (o[8]) m_stalls++;
    if (!mem_busy && !m_md_outstanding && redirect) m_flushes++;
    if (!m_md_outstanding) begin
      if (md_start && !md_done && !mem_busy) m_md_outstanding = 1;
    end else if (mem_busy) begin
      if (md_done) m_done_seen = 1;
    end else if (md_done || m_done_seen) begin
      m_md_outstanding = 0;
      m_done_seen      = 0;
    end
  endfunction

  task automatic compare_all(input string tag);
    check({tag, "_out"},    {pc_stall, if_id, id_ex, ex_mem, mem_wb}, model_out());
    check({tag, "_out4"},   {pc_stall4, if_id4, id_ex4, ex_mem4, mem_wb4}, model_out());
    check({tag, "_stall"},  stall_cnt,  sat(m_stalls, 16));
    check({tag, "_flush"},  flush_cnt,  sat(m_flushes, 16));
    check({tag, "_stall4"}, stall_cnt4, sat(m_stalls, 4));
    check({tag, "_flush4"}, flush_cnt4, sat(m_flushes, 4));
  endtask

  // One clock: compare mid-cycle, advance the model, then return just after the edge.
  task automatic step(input string tag);
    @(negedge clk);
    compare_all(tag);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs1 = 0; rs2 = 0; rd = 0; used1 = 0; used2 = 0; mem_read = 0;
    redirect = 0; md_start = 0; md_done = 0; mem_busy = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_out", {pc_stall, if_id, id_ex, ex_mem, mem_wb}, 9'b0);
    check("rst_cnt", {stall_cnt, flush_cnt}, 32'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    mem_busy = 1'b1;
    redirect = 1'b1;
    #2;
    check("rst_gated_out", {pc_stall, if_id, id_ex, ex_mem, mem_wb}, 9'b0);
    idle_inputs();
    do_reset();

    // Load-use on rs2, then same pattern with rd = x0.
    mem_read = 1; rd = 5; rs2 = 5; used2 = 1;
    step("lu");
    check("lu_stall_cnt", stall_cnt, 16'd1);
    rd = 0;
    step("lu_x0");
    check("lu_x0_stall_cnt", stall_cnt, 16'd1);
    idle_inputs();

    // Redirect overrides a simultaneous load-use.
    do_reset();
    mem_read = 1; rd = 7; rs1 = 7; used1 = 1; redirect = 1;
    step("redir");
    check("redir_cnts", {flush_cnt, stall_cnt}, {16'd1, 16'd0});
    idle_inputs();

    // Mul/div: start, done four cycles later.
    do_reset();
    md_start = 1;
    step("md_start");
    md_start = 0;
    repeat (3) step("md_wait");
    md_done = 1;
    step("md_done");
    md_done = 0;
    check("md_stall_cnt", stall_cnt, 16'd4);
    check("md_back_run", {pc_stall, ex_mem}, 3'b000);
    step("md_run");

    // Completion arrives during a memory freeze.
    do_reset();
    md_start = 1;
    step("bz_start");
    md_start = 0;
    step("bz_wait");
    mem_busy = 1; md_done = 1;
    step("bz_busy_done");
    md_done = 0;
    repeat (2) step("bz_busy");
    mem_busy = 0;
    step("bz_exit");
    check("bz_run", {pc_stall, if_id, id_ex, ex_mem, mem_wb}, 9'b0);
    step("bz_run2");

    // Twenty frozen cycles: narrow counter saturates.
    do_reset();
    mem_busy = 1;
    repeat (20) step("sat");
    mem_busy = 0;
    check("sat4", stall_cnt4, 4'd15);
    check("sat16", stall_cnt, 16'd20);

    // Reset asserted between edges in the middle of a mul/div wait.
    do_reset();
    md_start = 1;
    step("rm_start");
    md_start = 0;
    step("rm_wait");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rm_out", {pc_stall, if_id, id_ex, ex_mem, mem_wb}, 9'b0);
    check("rm_cnt", {stall_cnt, flush_cnt}, 32'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("rm_after");

    // Randomized traffic with small register indices to make hazards common.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rs1      = 5'($urandom_range(0, 3));
      rs2      = 5'($urandom_range(0, 3));
      rd       = 5'($urandom_range(0, 3));
      used1    = 1'($urandom);
      used2    = 1'($urandom);
      mem_read = 1'($urandom);
      redirect = ($urandom_range(0, 5) == 0);
      md_start = ($urandom_range(0, 7) == 0);
      md_done  = ($urandom_range(0, 4) == 0);
      mem_busy = ($urandom_range(0, 6) == 0);
      step("rnd");
    end
    idle_inputs();
    step("end");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
